// File: rtl/yuv_row_upsampler_csc_if.sv
// Pair-stream handshake bundle for the YUV row upsampler / CSC.
// Master drives YUV pairs and out_ready; slave returns RGB pairs.
interface yuv_row_upsampler_csc_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y0;
  logic [7:0] in_y1;
  logic [7:0] in_u;
  logic [7:0] in_v;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r0;
  logic [7:0] out_g0;
  logic [7:0] out_b0;
  logic [7:0] out_r1;
  logic [7:0] out_g1;
  logic [7:0] out_b1;
  logic       out_eol;

  modport master (
    output in_valid, in_y0, in_y1, in_u, in_v, out_ready,
    input  in_ready, out_valid, out_eol,
    input  out_r0, out_g0, out_b0, out_r1, out_g1, out_b1
  );

  modport slave (
    input  in_valid, in_y0, in_y1, in_u, in_v, out_ready,
    output in_ready, out_valid, out_eol,
    output out_r0, out_g0, out_b0, out_r1, out_g1, out_b1
  );
endinterface

// File: rtl/yuv_row_upsampler_csc.sv
// Streaming YUV 4:2:2 pair upsampler (6-tap / nearest odd chroma)
// followed by a shared YUV-to-RGB converter, one RGB pair per handshake.
module yuv_row_upsampler_csc #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic mode_nearest,
  yuv_row_upsampler_csc_if.slave bus,
  output logic frame_done
);

  localparam int P  = WIDTH / 2;
  localparam int CW = $clog2(P + 1);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {
    S_FILL, S_UV, S_EVEN, S_ODD, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] tx_cnt;
  logic [RW-1:0] row_cnt;
  logic          run;
  logic          mode_row;

  logic [7:0] y0_buf [4];
  logic [7:0] y1_buf [4];
  logic [7:0] u_buf  [8];
  logic [7:0] v_buf  [8];
  logic [7:0] uo, vo;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  logic [CW:0] tx_p4, fill_lim, rx_nxt;
  logic        accept, hs_out, last_pair;
  logic [2:0]  sl [6];
  logic [2:0]  c0;
  logic [1:0]  l0;
  logic [7:0]  cy, cu, cv;
  logic [23:0] rgb;

  function automatic logic [7:0] clip8(input int x);
    if (x < 0)        return 8'd0;
    else if (x > 255) return 8'd255;
    else              return x[7:0];
  endfunction

  function automatic logic [2:0] cslot(
    input logic [CW-1:0] k,
    input int            d
  );
    int j;
    j = int'(k) + d;
    if (j < 0)          j = 0;
    else if (j > P - 1) j = P - 1;
    return j[2:0];
  endfunction

  function automatic logic [7:0] fir(
    input logic [7:0] a, b, c, d, e, f
  );
    int s;
    s = 21 * int'(a) - 52 * int'(b)
      + 159 * int'(c) + 159 * int'(d)
      - 52 * int'(e) + 21 * int'(f) + 128;
    return clip8(s >>> 8);
  endfunction

  function automatic logic [23:0] csc(
    input logic [7:0] y, u, v
  );
    int yt, ut, vt, r, g, b;
    yt = 76284 * (int'(y) - 16);
    ut = int'(u) - 128;
    vt = int'(v) - 128;
    r  = (yt + 104595 * vt) >>> 16;
    g  = (yt - 25624 * ut - 53281 * vt) >>> 16;
    b  = (yt + 132251 * ut) >>> 16;
    return {clip8(r), clip8(g), clip8(b)};
  endfunction

  // Fill limit is min(tx+4, P): the window k-2..k+3 must be resident.
  assign tx_p4    = {1'b0, tx_cnt} + (CW+1)'(4);
  assign fill_lim = (tx_p4 < (CW+1)'(P)) ? tx_p4 : (CW+1)'(P);

  assign bus.in_ready = run && (state == S_FILL)
                     && ({1'b0, rx_cnt} < fill_lim);
  assign accept       = bus.in_valid && bus.in_ready;
  assign rx_nxt       = {1'b0, rx_cnt} + {{CW{1'b0}}, accept};

  assign bus.out_valid = (state == S_OUT);
  assign hs_out        = bus.out_valid && bus.out_ready;
  assign last_pair     = (tx_cnt == CW'(P - 1));
  assign bus.out_eol   = bus.out_valid && last_pair;

  assign bus.out_r0 = r0;
  assign bus.out_g0 = g0;
  assign bus.out_b0 = b0;
  assign bus.out_r1 = r1;
  assign bus.out_g1 = g1;
  assign bus.out_b1 = b1;

  assign c0 = tx_cnt[2:0];
  assign l0 = tx_cnt[1:0];

  always_comb begin
    for (int d = 0; d < 6; d++) begin
      sl[d] = cslot(tx_cnt, d - 2);
    end
  end

  // One converter serves both pixels of the pair.
  always_comb begin
    cy = y0_buf[l0];
    cu = u_buf[c0];
    cv = v_buf[c0];
    if (state == S_ODD) begin
      cy = y1_buf[l0];
      cu = uo;
      cv = vo;
    end
    rgb = csc(cy, cu, cv);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FILL: if (rx_nxt >= fill_lim) state_nxt = S_UV;
      S_UV:   state_nxt = S_EVEN;
      S_EVEN: state_nxt = S_ODD;
      S_ODD:  state_nxt = S_OUT;
      S_OUT:  if (hs_out) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      row_cnt    <= '0;
      run        <= 1'b0;
      mode_row   <= 1'b0;
      frame_done <= 1'b0;
      uo         <= '0;
      vo         <= '0;
      {r0, g0, b0} <= '0;
      {r1, g1, b1} <= '0;
      for (int i = 0; i < 4; i++) begin
        y0_buf[i] <= '0;
        y1_buf[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        u_buf[i] <= '0;
        v_buf[i] <= '0;
      end
    end else begin
      run        <= 1'b1;
      frame_done <= 1'b0;
      if (accept) begin
        y0_buf[rx_cnt[1:0]] <= bus.in_y0;
        y1_buf[rx_cnt[1:0]] <= bus.in_y1;
        u_buf[rx_cnt[2:0]]  <= bus.in_u;
        v_buf[rx_cnt[2:0]]  <= bus.in_v;
        rx_cnt <= rx_cnt + CW'(1);
        if (rx_cnt == '0) mode_row <= mode_nearest;
      end
      if (state == S_UV) begin
        if (mode_row) begin
          uo <= u_buf[c0];
          vo <= v_buf[c0];
        end else begin
          uo <= fir(u_buf[sl[0]], u_buf[sl[1]], u_buf[sl[2]],
                    u_buf[sl[3]], u_buf[sl[4]], u_buf[sl[5]]);
          vo <= fir(v_buf[sl[0]], v_buf[sl[1]], v_buf[sl[2]],
                    v_buf[sl[3]], v_buf[sl[4]], v_buf[sl[5]]);
        end
      end
      if (state == S_EVEN) {r0, g0, b0} <= rgb;
      if (state == S_ODD)  {r1, g1, b1} <= rgb;
      if (hs_out) begin
        if (last_pair) begin
          rx_cnt <= '0;
          tx_cnt <= '0;
          if (row_cnt == RW'(HEIGHT - 1)) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_yuv_row_upsampler_csc.sv
// Randomized row-level bench for yuv_row_upsampler_csc (WIDTH=8,
// HEIGHT=1) against a pixel-array reference of filter and CSC.
module tb_yuv_row_upsampler_csc;

  localparam int W = 8;
  localparam int H = 1;
  localparam int P = W / 2;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  logic mode_nearest = 1'b0;
  logic frame_done;

  always #5 Clock = ~Clock;

  yuv_row_upsampler_csc_if bus ();

  yuv_row_upsampler_csc #(.WIDTH(W), .HEIGHT(H)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .mode_nearest (mode_nearest),
    .bus          (bus),
    .frame_done   (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  int          ry0 [P];
  int          ry1 [P];
  int          ru  [P];
  int          rv  [P];
  bit          rmode;
  logic [47:0] expq [P];
  logic [47:0] obs  [P];
  int          accepted;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clipi(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic int clampk(input int j);
    return (j < 0) ? 0 : ((j > P - 1) ? P - 1 : j);
  endfunction

  function automatic logic [23:0] ref_rgb(input int y, u, v);
    int r, g, b;
    r = clipi((76284*(y-16) + 104595*(v-128)) >>> 16);
    g = clipi((76284*(y-16) - 25624*(u-128)
               - 53281*(v-128)) >>> 16);
    b = clipi((76284*(y-16) + 132251*(u-128)) >>> 16);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic int ref_odd(input int c [P], input int k);
    int taps [6] = '{21, -52, 159, 159, -52, 21};
    int s = 128;
    for (int d = 0; d < 6; d++) s += taps[d] * c[clampk(k + d - 2)];
    return clipi(s >>> 8);
  endfunction

  function automatic logic [47:0] ref_pair(input int k);
    int uo, vo;
    uo = rmode ? ru[k] : ref_odd(ru, k);
    vo = rmode ? rv[k] : ref_odd(rv, k);
    return {ref_rgb(ry0[k], ru[k], rv[k]), ref_rgb(ry1[k], uo, vo)};
  endfunction

  function automatic logic [47:0] outs();
    return {bus.out_r0, bus.out_g0, bus.out_b0,
            bus.out_r1, bus.out_g1, bus.out_b1};
  endfunction

  task automatic fill_row(input int y, input int u, input int v);
    for (int k = 0; k < P; k++) begin
      ry0[k] = y; ry1[k] = y; ru[k] = u; rv[k] = v;
    end
  endtask

  task automatic rand_row();
    for (int k = 0; k < P; k++) begin
      ry0[k] = $urandom_range(255);
      ry1[k] = $urandom_range(255);
      ru[k]  = $urandom_range(255);
      rv[k]  = $urandom_range(255);
    end
  endtask

  task automatic send_pair(input int k);
    int cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_y0 = 8'(ry0[k]);
    bus.in_y1 = 8'(ry1[k]);
    bus.in_u  = 8'(ru[k]);
    bus.in_v  = 8'(rv[k]);
    mode_nearest = (k == 0) ? rmode : 1'($urandom_range(1));
    forever begin
      @(negedge Clock);
      if (bus.in_ready) break;
      if (++cyc > 300) begin
        check("in_ready_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    @(posedge Clock); #1;
    accepted++;
    bus.in_valid = 1'b0;
  endtask

  // Caller is positioned just after a rising edge.
  task automatic run_row(
    input int stall,
    input int rdy_pct,
    input int gap_pct
  );
    for (int k = 0; k < P; k++) expq[k] = ref_pair(k);
    accepted = 0;
    fork
      begin : drv
        for (int k = 0; k < P; k++) begin
          while ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(posedge Clock); #1;
          end
          send_pair(k);
        end
      end
      begin : mon
        int k = 0, cyc = 0, sv = 0, fd = 0;
        while (k < P) begin
          @(negedge Clock);
          if (bus.out_valid && k == 0) sv++;
          if (stall > 0 && k == 0 && sv <= stall)
            bus.out_ready = 1'b0;
          else
            bus.out_ready = ($urandom_range(99) < rdy_pct);
          if (stall > 0 && k == 0 && sv == stall) begin
            check("stall_accepted", 64'(accepted), 64'(P < 4 ? P : 4));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          end
          if (bus.out_valid) begin
            check($sformatf("pair%0d", k), 64'(outs()), 64'(expq[k]));
            check($sformatf("eol%0d", k), 64'(bus.out_eol),
                  64'(k == P - 1));
            if (bus.out_ready) begin
              obs[k] = outs();
              k++;
            end
          end
          if (++cyc > 3000) begin
            check("out_valid_timeout", 64'(cyc), 64'd0);
            break;
          end
        end
        @(negedge Clock);
        bus.out_ready = 1'b0;
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        fd = int'(frame_done);
        repeat (3) begin
          @(negedge Clock);
          fd += int'(frame_done);
        end
        check("frame_done_count", 64'(fd), 64'd1);
      end
    join
    @(posedge Clock); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_y0     = '0;
    bus.in_y1     = '0;
    bus.in_u      = '0;
    bus.in_v      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_outs", 64'(outs()), 64'd0);
    check("rst_eol_fd", 64'({bus.out_eol, frame_done}), 64'd0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    rmode = 1'b0;
    fill_row(128, 128, 128);
    run_row(0, 100, 0);
    check("gold130_k0", 64'(obs[0]), 64'h828282828282);
    check("gold130_k3", 64'(obs[P-1]), 64'h828282828282);

    fill_row(16, 128, 128);
    run_row(0, 60, 20);
    check("clip_black", 64'(obs[1]), 64'd0);
    fill_row(255, 128, 128);
    run_row(0, 60, 20);
    check("clip_white", 64'(obs[2]), 64'hFFFFFFFFFFFF);

    fill_row(16, 128, 128);
    for (int k = 0; k < P; k++) ru[k] = 128 + 10 * k;
    run_row(0, 100, 0);
    check("interp_b1_k0", 64'(obs[0][7:0]), 64'd10);
    check("interp_b0_k1", 64'(obs[1][31:24]), 64'd20);
    check("interp_b0_k2", 64'(obs[2][31:24]), 64'd40);

    rmode = 1'b1;
    run_row(0, 100, 0);
    check("nearest_b1_k1", 64'(obs[1][7:0]), 64'd20);
    check("nearest_b0_k1", 64'(obs[1][31:24]), 64'd20);

    rmode = 1'b0;
    rand_row();
    run_row(10, 100, 0);

    for (int r = 0; r < 10; r++) begin
      rmode = 1'($urandom_range(1));
      rand_row();
      run_row(0, 70, 30);
    end

    rmode = 1'b0;
    rand_row();
    ry0[P-1] = 200;
    ry1[P-1] = 200;
    run_row(0, 100, 0);
    rand_row();
    send_pair(0);
    send_pair(1);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("midrst_outs", 64'(outs()), 64'd0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
    fill_row(128, 128, 128);
    run_row(0, 100, 0);
    check("post_rst_k0", 64'(obs[0]), 64'h828282828282);
    check("post_rst_k3", 64'(obs[P-1]), 64'h828282828282);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
